regfile_wb_arbiter: RTL

//  Write-back controller for the CR16 register file. Two requesters share the

---
 rtl/regfile_wb_arbiter.sv | 70 +++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and load write-backs onto the CR16 regfile port and tracks pending writes.
// Optional CR16_WB_ROUND_ROBIN_EN replaces fixed MEM priority with alternating grants.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_ALU_VALID,
  input  logic [3:0]  I_ALU_DEST,
  input  logic [15:0] I_ALU_DATA,
  output logic        O_ALU_READY,
  input  logic        I_MEM_VALID,
  input  logic [3:0]  I_MEM_DEST,
  input  logic [15:0] I_MEM_DATA,
  output logic        O_MEM_READY,
  input  logic        I_ISSUE_VALID,
  input  logic [3:0]  I_ISSUE_DEST,
  output logic [15:0] O_REG_BUS,
  output logic [15:0] O_REG_ENABLE,
  output logic [15:0] O_PENDING
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic [3:0]  alu_wait_q, alu_wait_d, mem_wait_q, mem_wait_d;
  logic        last_mem_q, last_mem_d;
  logic [15:0] reg_bus_q, reg_bus_d, reg_enable_q, reg_enable_d, pending_q, pending_d;
  logic        mem_win, alu_win, gnt;
  logic [3:0]  dest;
  logic [15:0] data, wr_mask;
  always_comb begin
`ifdef CR16_WB_ROUND_ROBIN_EN
    mem_win = I_MEM_VALID & (~I_ALU_VALID | ~last_mem_q);
`else
    mem_win = I_MEM_VALID & ~(I_ALU_VALID & (alu_wait_q == MW));
`endif
    alu_win = I_ALU_VALID & ~mem_win;
    O_MEM_READY = mem_win;
    O_ALU_READY = alu_win;
    gnt = mem_win | alu_win;
    dest = mem_win ? I_MEM_DEST : I_ALU_DEST;
    data = mem_win ? I_MEM_DATA : I_ALU_DATA;
    wr_mask = gnt ? 16'd1 << dest : 16'd0;
    alu_wait_d = (I_ALU_VALID & ~alu_win) ? ((alu_wait_q == MW) ? alu_wait_q : alu_wait_q + 4'd1) : 4'd0;
    mem_wait_d = (I_MEM_VALID & ~mem_win) ? ((mem_wait_q == MW) ? mem_wait_q : mem_wait_q + 4'd1) : 4'd0;
    last_mem_d = mem_win ? 1'b1 : (alu_win ? 1'b0 : last_mem_q);
    reg_enable_d = wr_mask;
    reg_bus_d = gnt ? data : reg_bus_q;
    // a same-cycle issue re-marks the register: the newer writer is still outstanding
    pending_d = (pending_q & ~wr_mask) | (I_ISSUE_VALID ? 16'd1 << I_ISSUE_DEST : 16'd0);
  end
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      alu_wait_q   <= '0;
      mem_wait_q   <= '0;
      last_mem_q   <= 1'b1;
      reg_bus_q    <= '0;
      reg_enable_q <= '0;
      pending_q    <= '0;
    end else begin
      alu_wait_q   <= alu_wait_d;
      mem_wait_q   <= mem_wait_d;
      last_mem_q   <= last_mem_d;
      reg_bus_q    <= reg_bus_d;
      reg_enable_q <= reg_enable_d;
      pending_q    <= pending_d;
    end
  end
  assign O_REG_BUS    = reg_bus_q;
  assign O_REG_ENABLE = reg_enable_q;
  assign O_PENDING    = pending_q;
endmodule
